mux_scan_seq: RTL and testbench

//  Upstream sequencer for the 4-to-1 2-bit field mux (MuxKey, 4 keys, 2-bit key, 2-bit data).
//  - Accepts one 8-bit word over a valid/ready handshake and holds it on the mux data input.
//  - Steps the mux select through all four fields at a paced rate.
//  - Registers each mux result and emits it with its field index, then pulses done.

---
 rtl/mux_scan_pkg.sv | 32 +++
 rtl/mux_scan_tick.sv | 29 ++
 rtl/mux_scan_seq.sv | 112 +++++++++++
 tb/tb_mux_scan_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-field mux scan sequencer.
// Scan direction is selected by SCAN_REVERSE_EN (undefined: select 0..3, MSB field first).
package mux_scan_pkg;

  localparam int unsigned FIELD_W  = 2;
  localparam int unsigned NR_FIELD = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned WORD_W   = FIELD_W * NR_FIELD;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

`ifdef SCAN_REVERSE_EN
  localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(NR_FIELD - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = '0;
`else
  localparam logic [SEL_W-1:0] SEL_FIRST = '0;
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NR_FIELD - 1);
`endif

  // Wraps mod 4; the scan always stops at SEL_LAST before a wrap could matter.
  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
`ifdef SCAN_REVERSE_EN
    return s - SEL_W'(1);
`else
    return s + SEL_W'(1);
`endif
  endfunction

endpackage

// File: rtl/mux_scan_tick.sv
// Step pacer: counts DIV enabled cycles; step is high on the last cycle of each step.
module mux_scan_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign step = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= step ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Upstream sequencer for the 4-to-1 field mux: holds one word, paces the select,
// captures each mux result. Scan direction set by SCAN_REVERSE_EN (see mux_scan_pkg).
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic [WORD_W-1:0]  mux_a,
  output logic [SEL_W-1:0]   mux_s,
  input  logic [FIELD_W-1:0] mux_y,
  output logic               out_valid,
  output logic [FIELD_W-1:0] out_field,
  output logic [SEL_W-1:0]   out_idx,
  output logic               done
);

  state_t r_state;
  state_t w_state_nxt;

  logic               w_accept;
  logic               w_step;
  logic               w_fire;
  logic               w_last;

  logic [WORD_W-1:0]  r_mux_a;
  logic [SEL_W-1:0]   r_mux_s;
  logic               r_out_valid;
  logic [FIELD_W-1:0] r_out_field;
  logic [SEL_W-1:0]   r_out_idx;
  logic               r_done;

  assign in_ready  = (r_state == IDLE);
  assign mux_a     = r_mux_a;
  assign mux_s     = r_mux_s;
  assign out_valid = r_out_valid;
  assign out_field = r_out_field;
  assign out_idx   = r_out_idx;
  assign done      = r_done;

  mux_scan_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (r_state == SCAN),
    .step  (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fire      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_step) begin
          w_fire = 1'b1;
          if (r_mux_s == SEL_LAST) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // mux_y is sampled only on the last cycle of a step, after a full DIV cycles of settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_a     <= '0;
      r_mux_s     <= SEL_FIRST;
      r_out_valid <= 1'b0;
      r_out_field <= '0;
      r_out_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= w_fire;
      r_done      <= w_last;
      if (w_accept) begin
        r_mux_a <= in_data;
        r_mux_s <= SEL_FIRST;
      end
      if (w_fire) begin
        r_out_field <= mux_y;
        r_out_idx   <= r_mux_s;
        if (!w_last) begin
          r_mux_s <= sel_next(r_mux_s);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: four lanes with DIV = 4, 1, 2, 7, each driving a behavioural 4-to-1 field mux.
module tb_mux_scan_seq;

  localparam int NL = 4;
`ifdef SCAN_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [NL];
  logic       in_valid  [NL];
  logic       in_ready  [NL];
  logic [7:0] in_data   [NL];
  logic [7:0] mux_a     [NL];
  logic [1:0] mux_s     [NL];
  logic [1:0] mux_y     [NL];
  logic       out_valid [NL];
  logic [1:0] out_field [NL];
  logic [1:0] out_idx   [NL];
  logic       done      [NL];

  int n_chk = 0;
  int n_pass = 0;
  bit fin_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int div_of(input int ln);
    case (ln)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 7;
    endcase
  endfunction

  // field k = bits [7-2k : 6-2k]
  function automatic logic [1:0] field_of(input logic [7:0] w, input logic [1:0] k);
    logic [7:0] t;
    t = w >> (6 - 2 * int'(k));
    return t[1:0];
  endfunction

  function automatic logic [1:0] exp_idx(input int j);
    return REV ? 2'(3 - j) : 2'(j);
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int unsigned D = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 7;

    mux_scan_seq #(.DIV(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .mux_a     (mux_a[g]),
      .mux_s     (mux_s[g]),
      .mux_y     (mux_y[g]),
      .out_valid (out_valid[g]),
      .out_field (out_field[g]),
      .out_idx   (out_idx[g]),
      .done      (done[g])
    );

    assign mux_y[g] = field_of(mux_a[g], mux_s[g]);

    logic [7:0] sb_word = '0;
    int         sb_step = 0;
    bit         sb_busy = 1'b0;
    int         n_acc = 0;
    int         n_done = 0;
    int         n_abort = 0;

    // Scoreboard: every out_valid must carry the next field of the last accepted word.
    always @(negedge clk) begin
      if (!rst_n[g]) begin
        if (sb_busy) n_abort++;
        sb_busy = 1'b0;
        sb_step = 0;
      end else begin
        if (out_valid[g]) begin
          chk($sformatf("L%0d_sb_busy", g), 32'(sb_busy), 1);
          chk($sformatf("L%0d_sb_idx", g), 32'(out_idx[g]), 32'(exp_idx(sb_step)));
          chk($sformatf("L%0d_sb_field", g), 32'(out_field[g]),
              32'(field_of(sb_word, exp_idx(sb_step))));
          chk($sformatf("L%0d_sb_done", g), 32'(done[g]), 32'(sb_step == 3));
          if (sb_step == 3) sb_busy = 1'b0;
          sb_step++;
        end
        if (done[g]) begin
          n_done++;
          chk($sformatf("L%0d_done_has_valid", g), 32'(out_valid[g]), 1);
        end
        if (in_valid[g] && in_ready[g]) begin
          sb_word = in_data[g];
          sb_step = 0;
          sb_busy = 1'b1;
          n_acc++;
        end
      end
    end

    initial begin
      wait (fin_req);
      chk($sformatf("L%0d_done_count", g), 32'(n_done), 32'(n_acc - n_abort));
    end
  end

  task automatic scan_word(input int ln, input logic [7:0] w, input bit hold, input logic [7:0] nxt);
    int d;
    int t;
    d = div_of(ln);
    in_valid[ln] = 1'b1;
    in_data[ln]  = w;
    t = 0;
    while (in_ready[ln] !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("L%0d_accept_wait", ln), 32'(in_ready[ln]), 1);
    @(posedge clk); #1;
    if (hold) in_data[ln] = nxt;
    else in_valid[ln] = 1'b0;
    chk($sformatf("L%0d_busy_rdy", ln), 32'(in_ready[ln]), 0);
    for (int j = 0; j < 4; j++) begin
      for (int c = 1; c <= d; c++) begin
        @(posedge clk); #1;
        chk($sformatf("L%0d_ov_j%0d_c%0d", ln, j, c), 32'(out_valid[ln]), 32'(c == d));
        chk($sformatf("L%0d_rdy_j%0d_c%0d", ln, j, c), 32'(in_ready[ln]), 32'(j == 3 && c == d));
        if (c == d) begin
          chk($sformatf("L%0d_idx_j%0d", ln, j), 32'(out_idx[ln]), 32'(exp_idx(j)));
          chk($sformatf("L%0d_field_j%0d", ln, j), 32'(out_field[ln]), 32'(field_of(w, exp_idx(j))));
          chk($sformatf("L%0d_done_j%0d", ln, j), 32'(done[ln]), 32'(j == 3));
          chk($sformatf("L%0d_mux_a_j%0d", ln, j), 32'(mux_a[ln]), 32'(w));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    logic [7:0] nxt;
    bit         back;
    for (int i = 0; i < NL; i++) begin
      rst_n[i]    = 1'b0;
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
    end
    #2;
    chk("rst_in_ready", 32'(in_ready[0]), 1);
    chk("rst_out_valid", 32'(out_valid[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_mux_a", 32'(mux_a[0]), 0);
    chk("rst_mux_s", 32'(mux_s[0]), REV ? 3 : 0);
    chk("rst_out_field", 32'(out_field[0]), 0);
    chk("rst_out_idx", 32'(out_idx[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) rst_n[i] = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready[0]), 1);

    // Basic scan, then check the pulses last one cycle and mux_a holds the word.
    scan_word(0, 8'hE4, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk("pulse_ov_clear", 32'(out_valid[0]), 0);
    chk("pulse_done_clear", 32'(done[0]), 0);
    chk("hold_mux_a", 32'(mux_a[0]), 8'hE4);
    chk("idle_ready", 32'(in_ready[0]), 1);

    // in_valid held through a scan: 8'hFF waits and is taken right after done.
    scan_word(0, 8'h1B, 1'b1, 8'hFF);
    scan_word(0, 8'hFF, 1'b0, 8'h00);

    // Asynchronous reset mid-scan.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hE4;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_pre_field", 32'(out_field[0]), 32'(field_of(8'hE4, exp_idx(1))));
    rst_n[0] = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid[0]), 0);
    chk("mid_out_field", 32'(out_field[0]), 0);
    chk("mid_out_idx", 32'(out_idx[0]), 0);
    chk("mid_done", 32'(done[0]), 0);
    chk("mid_mux_a", 32'(mux_a[0]), 0);
    chk("mid_mux_s", 32'(mux_s[0]), REV ? 3 : 0);
    chk("mid_in_ready", 32'(in_ready[0]), 1);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_quiet_ov_%0d", c), 32'(out_valid[0]), 0);
      chk($sformatf("mid_quiet_done_%0d", c), 32'(done[0]), 0);
    end
    scan_word(0, 8'h96, 1'b0, 8'h00);

    // DIV=1, back-to-back words.
    scan_word(1, 8'hA5, 1'b1, 8'h5A);
    scan_word(1, 8'h5A, 1'b0, 8'h00);

    // Random words on DIV = 1, 2, 7, mixing back-to-back and gapped accepts.
    for (int ln = 1; ln < NL; ln++) begin
      w = 8'($urandom_range(0, 255));
      for (int i = 0; i < 6; i++) begin
        nxt  = 8'($urandom_range(0, 255));
        back = (i < 5) && ($urandom_range(0, 1) == 1);
        scan_word(ln, w, back, nxt);
        if (!back) repeat ($urandom_range(0, 3)) @(posedge clk);
        #0;
        w = nxt;
      end
      repeat (3) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    fin_req = 1'b1;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
